// File: rtl/clock_pkg.sv
// Shared constants, field/state encodings and wrap helper for the clock
// time-setting logic.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HRS  = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;
  localparam logic [1:0] FLD_SEC  = 2'd3;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HRS    = 3'd1;
  localparam state_t ST_MIN    = 3'd2;
  localparam state_t ST_SEC    = 3'd3;
  localparam state_t ST_COMMIT = 3'd4;

  localparam logic [MIN_W-1:0]  MAX_MIN_SEC = 6'd59;
  localparam logic [HOUR_W-1:0] MAX_H24     = 5'd23;
  localparam logic [HOUR_W-1:0] MAX_H12     = 5'd12;

  // One step inside [lo, hi], wrapping at either end; never carries.
  function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                           input logic [5:0] lo,
                                           input logic [5:0] hi,
                                           input logic       up);
    if (up) return (val == hi) ? lo : val + 6'd1;
    return (val == lo) ? hi : val - 6'd1;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button edge detect plus hold-to-repeat timer; emits one-cycle step pulses
// on the press edge, after RPT_DELAY held cycles, then every RPT_PERIOD.
module btn_repeat #(
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic clr_i,
  output logic step_o
);

  localparam int            CW       = $clog2(RPT_DELAY + 1);
  localparam logic [CW-1:0] DELAY_C  = CW'(RPT_DELAY);
  localparam logic [CW-1:0] PERIOD_C = CW'(RPT_PERIOD);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic          btn_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rpt_q, rpt_d;
  logic          rise, fire;

  assign rise   = btn_i & ~btn_q;
  assign fire   = btn_i & btn_q & (cnt_q == (rpt_q ? PERIOD_C : DELAY_C));
  assign step_o = rise | fire;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    rpt_d = rpt_q;
    if (clr_i || !btn_i) begin
      cnt_d = '0;
      rpt_d = 1'b0;
    end else if (rise) begin
      cnt_d = CW'(1);
      rpt_d = 1'b0;
    end else if (fire) begin
      cnt_d = CW'(1);
      rpt_d = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
      cnt_q <= cnt_d;
      rpt_q <= rpt_d;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: captures live time, edits
// hours/minutes/seconds with wrap and auto-repeat, commits with a load strobe.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int HOUR_MODE  = 24,
  parameter int SET_SECS   = 1,
  parameter int RPT_DELAY  = 50_000_000,
  parameter int RPT_PERIOD = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic              next_i,
  input  logic              cancel_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic [HOUR_W-1:0] hours_i,
  input  logic [MIN_W-1:0]  mins_i,
  input  logic [SEC_W-1:0]  secs_i,
  input  logic              pm_i,
  output logic [HOUR_W-1:0] hours_o,
  output logic [MIN_W-1:0]  mins_o,
  output logic [SEC_W-1:0]  secs_o,
  output logic              pm_o,
  output logic [1:0]        field_o,
  output logic              setting_o,
  output logic              load_o
);

  localparam bit                H12   = (HOUR_MODE == 12);
  localparam logic [HOUR_W-1:0] H_MIN = H12 ? 5'd1 : 5'd0;
  localparam logic [HOUR_W-1:0] H_MAX = H12 ? MAX_H12 : MAX_H24;
  localparam logic [HOUR_W-1:0] H_RST = H12 ? MAX_H12 : 5'd0;

  state_t            state_q, state_d;
  logic              set_q, set_rise, editing, both, rpt_clr;
  logic              inc_raw, dec_raw, inc_step, dec_step;
  logic              hrs_ok;
  logic [HOUR_W-1:0] hours_q, hours_d;
  logic [MIN_W-1:0]  mins_q, mins_d;
  logic [SEC_W-1:0]  secs_q, secs_d;
  logic              pm_q, pm_d;
  logic [1:0]        field_q, field_d;
  logic              setting_q, setting_d, load_q, load_d;

  assign set_rise = set_i & ~set_q;
  assign editing  = (state_q == ST_HRS) || (state_q == ST_MIN) || (state_q == ST_SEC);
  assign both     = inc_i & dec_i;
  assign rpt_clr  = ~editing | both | next_i | cancel_i;
  // Cancel and a simultaneous inc+dec both suppress stepping.
  assign inc_step = inc_raw & editing & ~both & ~cancel_i;
  assign dec_step = dec_raw & editing & ~both & ~cancel_i;

  btn_repeat #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_inc_rpt (
    .clk(clk), .rst(rst), .btn_i(inc_i), .clr_i(rpt_clr), .step_o(inc_raw)
  );

  btn_repeat #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_dec_rpt (
    .clk(clk), .rst(rst), .btn_i(dec_i), .clr_i(rpt_clr), .step_o(dec_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (set_rise) state_d = ST_HRS;
      ST_HRS:    if (cancel_i) state_d = ST_IDLE;
                 else if (next_i) state_d = ST_MIN;
      ST_MIN:    if (cancel_i) state_d = ST_IDLE;
                 else if (next_i) state_d = (SET_SECS != 0) ? ST_SEC : ST_COMMIT;
      ST_SEC:    if (cancel_i) state_d = ST_IDLE;
                 else if (next_i) state_d = ST_COMMIT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state and registered, so they align with it.
  always_comb begin
    setting_d = (state_d != ST_IDLE);
    load_d    = (state_d == ST_COMMIT);
    field_d   = FLD_NONE;
    case (state_d)
      ST_HRS:  field_d = FLD_HRS;
      ST_MIN:  field_d = FLD_MIN;
      ST_SEC:  field_d = FLD_SEC;
      default: field_d = FLD_NONE;
    endcase
  end

  always_comb begin
    hours_d = hours_q;
    mins_d  = mins_q;
    secs_d  = secs_q;
    pm_d    = pm_q;
    hrs_ok  = (hours_i <= H_MAX) && (!H12 || hours_i != '0);
    if (state_q == ST_IDLE && set_rise) begin
      hours_d = hrs_ok ? hours_i : H_RST;
      mins_d  = (mins_i > MAX_MIN_SEC) ? '0 : mins_i;
      secs_d  = (secs_i > MAX_MIN_SEC) ? '0 : secs_i;
      pm_d    = H12 & pm_i;
    end else if (state_q == ST_IDLE || (editing && cancel_i)) begin
      hours_d = hours_i;
      mins_d  = mins_i;
      secs_d  = secs_i;
      pm_d    = H12 & pm_i;
    end else if (editing) begin
      if (inc_step || dec_step) begin
        case (state_q)
          ST_HRS: begin
            hours_d = HOUR_W'(wrap_step(6'(hours_q), 6'(H_MIN), 6'(H_MAX), inc_step));
            // PM flips only across the 11/12 boundary, not on the 12/1 wrap.
            if (H12 && ((inc_step && hours_q == 5'd11) || (dec_step && hours_q == MAX_H12)))
              pm_d = ~pm_q;
          end
          ST_MIN:  mins_d = wrap_step(mins_q, '0, MAX_MIN_SEC, inc_step);
          default: secs_d = wrap_step(secs_q, '0, MAX_MIN_SEC, inc_step);
        endcase
      end
      if (SET_SECS == 0 && state_d == ST_COMMIT) secs_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_q     <= 1'b0;
      hours_q   <= H_RST;
      mins_q    <= '0;
      secs_q    <= '0;
      pm_q      <= 1'b0;
      field_q   <= FLD_NONE;
      setting_q <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      set_q     <= set_i;
      hours_q   <= hours_d;
      mins_q    <= mins_d;
      secs_q    <= secs_d;
      pm_q      <= pm_d;
      field_q   <= field_d;
      setting_q <= setting_d;
      load_q    <= load_d;
    end
  end

  assign hours_o   = hours_q;
  assign mins_o    = mins_q;
  assign secs_o    = secs_q;
  assign pm_o      = pm_q;
  assign field_o   = field_q;
  assign setting_o = setting_q;
  assign load_o    = load_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: three configurations (24h, 12h,
// 24h without seconds) share stimulus; each scenario checks its own instance.
module tb_time_set_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, set_i, next_i, cancel_i, inc_i, dec_i, pm_i;
  logic [4:0] hours_i;
  logic [5:0] mins_i, secs_i;

  // Index 0: 24h, 1: 12h, 2: 24h without seconds field.
  logic [4:0] hr_o  [3];
  logic [5:0] mn_o  [3];
  logic [5:0] sc_o  [3];
  logic       pm_o  [3];
  logic [1:0] fld_o [3];
  logic       set_o [3];
  logic       ld_o  [3];

  int checks   = 0;
  int failures = 0;
  int loads [3] = '{0, 0, 0};

  time_set_ctrl #(.HOUR_MODE(24), .SET_SECS(1), .RPT_DELAY(10), .RPT_PERIOD(4)) u_h24 (
    .clk(clk), .rst(rst), .set_i(set_i), .next_i(next_i), .cancel_i(cancel_i),
    .inc_i(inc_i), .dec_i(dec_i), .hours_i(hours_i), .mins_i(mins_i), .secs_i(secs_i),
    .pm_i(pm_i), .hours_o(hr_o[0]), .mins_o(mn_o[0]), .secs_o(sc_o[0]), .pm_o(pm_o[0]),
    .field_o(fld_o[0]), .setting_o(set_o[0]), .load_o(ld_o[0])
  );

  time_set_ctrl #(.HOUR_MODE(12), .SET_SECS(1), .RPT_DELAY(10), .RPT_PERIOD(4)) u_h12 (
    .clk(clk), .rst(rst), .set_i(set_i), .next_i(next_i), .cancel_i(cancel_i),
    .inc_i(inc_i), .dec_i(dec_i), .hours_i(hours_i), .mins_i(mins_i), .secs_i(secs_i),
    .pm_i(pm_i), .hours_o(hr_o[1]), .mins_o(mn_o[1]), .secs_o(sc_o[1]), .pm_o(pm_o[1]),
    .field_o(fld_o[1]), .setting_o(set_o[1]), .load_o(ld_o[1])
  );

  time_set_ctrl #(.HOUR_MODE(24), .SET_SECS(0), .RPT_DELAY(10), .RPT_PERIOD(4)) u_nosec (
    .clk(clk), .rst(rst), .set_i(set_i), .next_i(next_i), .cancel_i(cancel_i),
    .inc_i(inc_i), .dec_i(dec_i), .hours_i(hours_i), .mins_i(mins_i), .secs_i(secs_i),
    .pm_i(pm_i), .hours_o(hr_o[2]), .mins_o(mn_o[2]), .secs_o(sc_o[2]), .pm_o(pm_o[2]),
    .field_o(fld_o[2]), .setting_o(set_o[2]), .load_o(ld_o[2])
  );

  always @(negedge clk)
    for (int d = 0; d < 3; d++) if (ld_o[d] === 1'b1) loads[d]++;

  // ---------------- reference helpers ----------------
  function automatic logic [17:0] obs(int d);
    return {hr_o[d], mn_o[d], sc_o[d], pm_o[d]};
  endfunction

  function automatic logic [17:0] tpack(int h, int m, int s, bit p);
    return {5'(h), 6'(m), 6'(s), p};
  endfunction

  function automatic int step_h(int mode, int h, bit up);
    if (mode == 24) return up ? (h + 1) % 24 : (h + 23) % 24;
    return up ? (h % 12) + 1 : ((h + 10) % 12) + 1;
  endfunction

  function automatic int step_ms(int v, bit up);
    return up ? (v + 1) % 60 : (v + 59) % 60;
  endfunction

  function automatic bit pm_flip(int h, bit up);
    return (up && h == 11) || (!up && h == 12);
  endfunction

  // ---------------- drive helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    set_i = 0; next_i = 0; cancel_i = 0; inc_i = 0; dec_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; cyc(); cyc(); rst = 0;
  endtask

  task automatic enter_set();
    set_i = 1; cyc(); set_i = 0;
  endtask

  task automatic press(bit up, int hold);
    if (up) inc_i = 1; else dec_i = 1;
    repeat (hold) cyc();
    inc_i = 0; dec_i = 0;
    cyc();
  endtask

  task automatic adv();
    next_i = 1; cyc(); next_i = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    hours_i = 5'd17; mins_i = 6'd42; secs_i = 6'd7; pm_i = 1;
    rst = 1; cyc(); cyc();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== tpack(d == 1 ? 12 : 0, 0, 0, 0) || fld_o[d] !== 2'd0 ||
          set_o[d] !== 1'b0 || ld_o[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_values dut%0d got=%h/%0d/%b/%b exp=%h/0/0/0", d, obs(d),
                 fld_o[d], set_o[d], ld_o[d], tpack(d == 1 ? 12 : 0, 0, 0, 0));
      end
    end
    rst = 0; cyc();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== tpack(17, 42, 7, d == 1)) begin
        failures++;
        $display("FAIL idle_track dut%0d got=%h exp=%h", d, obs(d), tpack(17, 42, 7, d == 1));
      end
    end
  endtask

  task automatic test_wrap24();
    int base;
    do_reset();
    hours_i = 5'd23; mins_i = 6'd59; secs_i = 6'd59; pm_i = 0;
    cyc();
    enter_set();
    checks++;
    if (set_o[0] !== 1'b1 || fld_o[0] !== 2'd1) begin
      failures++;
      $display("FAIL set_entry got setting=%b field=%0d exp setting=1 field=1", set_o[0], fld_o[0]);
    end
    press(1, 1);
    checks++;
    if (obs(0) !== tpack(0, 59, 59, 0)) begin
      failures++;
      $display("FAIL wrap24_inc got=%h exp=%h", obs(0), tpack(0, 59, 59, 0));
    end
    base = loads[0];
    adv();
    checks++;
    if (fld_o[0] !== 2'd2) begin
      failures++;
      $display("FAIL field_mins got=%0d exp=2", fld_o[0]);
    end
    adv();
    checks++;
    if (fld_o[0] !== 2'd3) begin
      failures++;
      $display("FAIL field_secs got=%0d exp=3", fld_o[0]);
    end
    adv();
    checks++;
    if (ld_o[0] !== 1'b1 || set_o[0] !== 1'b1 || obs(0) !== tpack(0, 59, 59, 0)) begin
      failures++;
      $display("FAIL commit24 got load=%b setting=%b val=%h exp load=1 setting=1 val=%h",
               ld_o[0], set_o[0], obs(0), tpack(0, 59, 59, 0));
    end
    cyc();
    checks++;
    if (ld_o[0] !== 1'b0 || set_o[0] !== 1'b0 || loads[0] - base !== 1) begin
      failures++;
      $display("FAIL commit24_end got load=%b setting=%b pulses=%0d exp load=0 setting=0 pulses=1",
               ld_o[0], set_o[0], loads[0] - base);
    end
  endtask

  task automatic test_pm12();
    int m, s;
    int exp_h [4] = '{12, 1, 12, 11};
    bit exp_p [4] = '{1, 1, 1, 0};
    bit dir   [4] = '{1, 1, 0, 0};
    do_reset();
    m = int'($urandom_range(0, 59)); s = int'($urandom_range(0, 59));
    hours_i = 5'd11; mins_i = 6'(m); secs_i = 6'(s); pm_i = 0;
    cyc();
    enter_set();
    checks++;
    if (obs(1) !== tpack(11, m, s, 0)) begin
      failures++;
      $display("FAIL pm12_capture got=%h exp=%h", obs(1), tpack(11, m, s, 0));
    end
    for (int i = 0; i < 4; i++) begin
      press(dir[i], 1);
      checks++;
      if (obs(1) !== tpack(exp_h[i], m, s, exp_p[i])) begin
        failures++;
        $display("FAIL pm12_step%0d got=%h exp=%h", i, obs(1), tpack(exp_h[i], m, s, exp_p[i]));
      end
    end
    cancel_i = 1; cyc(); cancel_i = 0;
  endtask

  task automatic test_repeat();
    int h, s, expm;
    do_reset();
    h = int'($urandom_range(0, 23)); s = int'($urandom_range(0, 59));
    hours_i = 5'(h); mins_i = 6'd0; secs_i = 6'(s); pm_i = 0;
    cyc();
    enter_set();
    adv();
    inc_i = 1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      expm = 1 + ((k >= 10) ? 1 + (k - 10) / 4 : 0);
      checks++;
      if (mn_o[0] !== 6'(expm)) begin
        failures++;
        $display("FAIL repeat_cycle%0d got=%0d exp=%0d", k, mn_o[0], expm);
      end
    end
    inc_i = 0;
    repeat (12) cyc();
    checks++;
    if (obs(0) !== tpack(h, 6, s, 0)) begin
      failures++;
      $display("FAIL repeat_release got=%h exp=%h", obs(0), tpack(h, 6, s, 0));
    end
    cancel_i = 1; cyc(); cancel_i = 0;
  endtask

  task automatic test_cancel();
    int base, nm;
    do_reset();
    hours_i = 5'($urandom_range(0, 23)); mins_i = 6'd30; secs_i = 6'($urandom_range(0, 59));
    cyc();
    enter_set();
    adv();
    repeat (3) press(1, 1);
    checks++;
    if (mn_o[0] !== 6'd33) begin
      failures++;
      $display("FAIL cancel_edit got=%0d exp=33", mn_o[0]);
    end
    base = loads[0];
    cancel_i = 1; next_i = 1; cyc(); cancel_i = 0; next_i = 0;
    checks++;
    if (set_o[0] !== 1'b0 || fld_o[0] !== 2'd0 || mn_o[0] !== 6'd30) begin
      failures++;
      $display("FAIL cancel_exit got setting=%b field=%0d mins=%0d exp setting=0 field=0 mins=30",
               set_o[0], fld_o[0], mn_o[0]);
    end
    nm = int'($urandom_range(0, 59));
    mins_i = 6'(nm);
    cyc();
    checks++;
    if (mn_o[0] !== 6'(nm)) begin
      failures++;
      $display("FAIL cancel_track got=%0d exp=%0d", mn_o[0], nm);
    end
    repeat (3) cyc();
    checks++;
    if (loads[0] !== base) begin
      failures++;
      $display("FAIL cancel_noload got=%0d exp=0", loads[0] - base);
    end
  endtask

  task automatic test_rst_clamp();
    int base;
    do_reset();
    hours_i = 5'd10; mins_i = 6'd20; secs_i = 6'd30; pm_i = 0;
    cyc();
    enter_set();
    adv(); adv();
    press(1, 1);
    base = loads[0];
    rst = 1; cyc(); rst = 0;
    checks++;
    if (set_o[0] !== 1'b0 || ld_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_midedit got setting=%b load=%b exp setting=0 load=0", set_o[0], ld_o[0]);
    end
    hours_i = 5'd27; mins_i = 6'd61; secs_i = 6'd45; pm_i = 1;
    cyc();
    enter_set();
    checks++;
    if (obs(0) !== tpack(0, 0, 45, 0)) begin
      failures++;
      $display("FAIL clamp24 got=%h exp=%h", obs(0), tpack(0, 0, 45, 0));
    end
    checks++;
    if (obs(1) !== tpack(12, 0, 45, 1)) begin
      failures++;
      $display("FAIL clamp12 got=%h exp=%h", obs(1), tpack(12, 0, 45, 1));
    end
    cancel_i = 1; cyc(); cancel_i = 0;
    repeat (2) cyc();
    checks++;
    if (loads[0] !== base) begin
      failures++;
      $display("FAIL rst_noload got=%0d exp=0", loads[0] - base);
    end
  endtask

  task automatic test_no_secs();
    int h, m, s, base;
    do_reset();
    h = int'($urandom_range(0, 23)); m = int'($urandom_range(0, 59)); s = int'($urandom_range(1, 59));
    hours_i = 5'(h); mins_i = 6'(m); secs_i = 6'(s); pm_i = 0;
    cyc();
    enter_set();
    inc_i = 1; dec_i = 1;
    repeat (15) cyc();
    inc_i = 0; dec_i = 0;
    cyc();
    checks++;
    if (obs(2) !== tpack(h, m, s, 0)) begin
      failures++;
      $display("FAIL both_held got=%h exp=%h", obs(2), tpack(h, m, s, 0));
    end
    press(1, 1);
    h = step_h(24, h, 1);
    adv();
    press(0, 1);
    m = step_ms(m, 0);
    checks++;
    if (obs(2) !== tpack(h, m, s, 0) || fld_o[2] !== 2'd2) begin
      failures++;
      $display("FAIL nosec_edit got=%h field=%0d exp=%h field=2", obs(2), fld_o[2], tpack(h, m, s, 0));
    end
    base = loads[2];
    adv();
    checks++;
    if (ld_o[2] !== 1'b1 || obs(2) !== tpack(h, m, 0, 0)) begin
      failures++;
      $display("FAIL nosec_commit got load=%b val=%h exp load=1 val=%h", ld_o[2], obs(2), tpack(h, m, 0, 0));
    end
    cyc();
    checks++;
    if (ld_o[2] !== 1'b0 || set_o[2] !== 1'b0 || loads[2] - base !== 1) begin
      failures++;
      $display("FAIL nosec_end got load=%b setting=%b pulses=%0d exp load=0 setting=0 pulses=1",
               ld_o[2], set_o[2], loads[2] - base);
    end
  endtask

  task automatic test_random();
    int eh [2], em [2], es [2];
    bit ep [2];
    int lh, lm, ls, n;
    bit lp, up;
    do_reset();
    for (int sess = 0; sess < 6; sess++) begin
      lh = int'($urandom_range(0, 31)); lm = int'($urandom_range(0, 63));
      ls = int'($urandom_range(0, 63)); lp = 1'($urandom_range(0, 1));
      hours_i = 5'(lh); mins_i = 6'(lm); secs_i = 6'(ls); pm_i = lp;
      cyc();
      eh[0] = (lh > 23) ? 0 : lh;
      eh[1] = (lh == 0 || lh > 12) ? 12 : lh;
      ep[0] = 0; ep[1] = lp;
      for (int d = 0; d < 2; d++) begin
        em[d] = (lm > 59) ? 0 : lm;
        es[d] = (ls > 59) ? 0 : ls;
      end
      enter_set();
      hours_i = 5'($urandom); mins_i = 6'($urandom); secs_i = 6'($urandom); pm_i = 1'($urandom);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs(d) !== tpack(eh[d], em[d], es[d], ep[d])) begin
          failures++;
          $display("FAIL rnd_capture s%0d dut%0d got=%h exp=%h", sess, d, obs(d), tpack(eh[d], em[d], es[d], ep[d]));
        end
      end
      for (int f = 0; f < 3; f++) begin
        n = int'($urandom_range(0, 4));
        for (int p = 0; p < n; p++) begin
          up = 1'($urandom_range(0, 1));
          press(up, int'($urandom_range(1, 3)));
          for (int d = 0; d < 2; d++) begin
            if (f == 0) begin
              if (d == 1 && pm_flip(eh[d], up)) ep[d] = ~ep[d];
              eh[d] = step_h(d == 0 ? 24 : 12, eh[d], up);
            end else if (f == 1) em[d] = step_ms(em[d], up);
            else es[d] = step_ms(es[d], up);
            checks++;
            if (obs(d) !== tpack(eh[d], em[d], es[d], ep[d])) begin
              failures++;
              $display("FAIL rnd_step s%0d f%0d dut%0d got=%h exp=%h", sess, f, d, obs(d),
                       tpack(eh[d], em[d], es[d], ep[d]));
            end
          end
        end
        adv();
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ld_o[d] !== 1'b1 || obs(d) !== tpack(eh[d], em[d], es[d], ep[d])) begin
          failures++;
          $display("FAIL rnd_commit s%0d dut%0d got load=%b val=%h exp load=1 val=%h", sess, d,
                   ld_o[d], obs(d), tpack(eh[d], em[d], es[d], ep[d]));
        end
      end
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1; pm_i = 0; hours_i = '0; mins_i = '0; secs_i = '0;
    test_reset();
    test_wrap24();
    test_pm12();
    test_repeat();
    test_cancel();
    test_rst_clamp();
    test_no_secs();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
